// File: rtl/led_phase_sequencer_pkg.sv
// Shared definitions for the LED phase sequencer: FSM encoding, active-low
// seven-segment glyphs (seg[7]=dp, seg[6:0]=g..a) and anode select patterns.
package led_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] GLYPH_BLANK   = 8'hFF;
    localparam logic [7:0] GLYPH_P       = 8'h8C;
    localparam logic [7:0] GLYPH_LOWER_D = 8'hA1;
    localparam logic [7:0] GLYPH_DASH    = 8'hBF;
    localparam logic [7:0] GLYPH_F       = 8'h8E;
    localparam logic [7:0] DP_ON_MASK    = 8'h7F;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [7:0] hex_glyph(input logic [3:0] value);
        logic [7:0] g;
        case (value)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // A divisor of 1 still needs a one-bit counter to keep the vectors legal.
    function automatic int count_width(input int divisor);
        return (divisor > 1) ? $clog2(divisor) : 1;
    endfunction

endpackage

// File: rtl/led_phase_sequencer_seg_scan.sv
// Four-digit multiplexer for an active-low seven-segment display; steps from
// digit 3 down to digit 0, holding each for SCAN_DIV cycles.
module led_phase_sequencer_seg_scan
    import led_phase_sequencer_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] glyph3,
    input  logic [7:0] glyph2,
    input  logic [7:0] glyph1,
    input  logic [7:0] glyph0,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SCAN_W = count_width(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [1:0]        digit;
    logic [7:0]        glyph_sel;
    logic [3:0]        an_sel;

    // Runs regardless of enable so the digit rhythm never restarts mid-run.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        slot_d     = slot_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            slot_d     = slot_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            slot_q     <= 2'd0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            slot_q     <= slot_d;
        end
    end

    assign digit = 2'd3 - slot_q;

    always_comb begin
        glyph_sel = GLYPH_BLANK;
        an_sel    = AN_OFF;
        case (digit)
            2'd3: begin glyph_sel = glyph3; an_sel = AN_DIG3; end
            2'd2: begin glyph_sel = glyph2; an_sel = AN_DIG2; end
            2'd1: begin glyph_sel = glyph1; an_sel = AN_DIG1; end
            default: begin glyph_sel = glyph0; an_sel = AN_DIG0; end
        endcase
    end

    assign seg = enable ? glyph_sel : GLYPH_BLANK;
    assign an  = enable ? an_sel : AN_OFF;

endmodule

// File: rtl/led_phase_sequencer.sv
// Multi-phase LED bar-fill sequencer: NUM_PHASES sweeps with step divider,
// pause, manual or timed advance, and a "P ?x" status readout.
module led_phase_sequencer
    import led_phase_sequencer_pkg::*;
#(
    parameter int LED_W        = 13,
    parameter int STEP_DIV     = 25_000_000,
    parameter int NUM_PHASES   = 4,
    parameter int AUTO_ADVANCE = 0,
    parameter int HOLD_DIV     = 50_000_000,
    parameter int SCAN_DIV     = 100_000
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             next,
    input  logic             pause,
    output logic [LED_W-1:0] LED,
    output logic [7:0]       seg,
    output logic [3:0]       an,
    output logic [3:0]       phase,
    output logic             phase_done,
    output logic             done
);

    localparam int TICK_W = count_width(STEP_DIV);
    localparam int HOLD_W = count_width(HOLD_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_DIV - 1);
    localparam logic [3:0]        PHASE_LAST = 4'(NUM_PHASES - 1);
    localparam logic [LED_W-1:0]  LED_FULL   = {LED_W{1'b1}};

    state_t            state_q, state_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [3:0]        phase_q, phase_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              phase_done_q, phase_done_d;
    logic              advance;

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        phase_d      = phase_q;
        tick_d       = tick_q;
        hold_d       = hold_q;
        phase_done_d = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FILL;
                    led_d   = '0;
                    phase_d = 4'd0;
                    tick_d  = '0;
                    hold_d  = '0;
                end
            end

            ST_FILL: begin
                // A full bar is seen one cycle after it lands, so the pulse
                // lines up with the FULL state rather than the last step.
                if (led_q == LED_FULL) begin
                    state_d      = ST_FULL;
                    phase_done_d = 1'b1;
                    hold_d       = '0;
                end else if (!pause) begin
                    if (tick_q == TICK_LAST) begin
                        led_d  = {led_q[LED_W-2:0], 1'b1};
                        tick_d = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_FULL: begin
                if (phase_q == PHASE_LAST) begin
                    state_d = ST_DONE;
                end else if (AUTO_ADVANCE != 0) begin
                    if (!pause) begin
                        if (hold_q == HOLD_LAST) begin
                            advance = 1'b1;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end else if (next) begin
                    advance = 1'b1;
                end

                if (advance) begin
                    state_d = ST_FILL;
                    led_d   = '0;
                    phase_d = phase_q + 4'd1;
                    tick_d  = '0;
                    hold_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            led_q        <= '0;
            phase_q      <= 4'd0;
            tick_q       <= '0;
            hold_q       <= '0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            phase_q      <= phase_d;
            tick_q       <= tick_d;
            hold_q       <= hold_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign LED        = led_q;
    assign phase      = phase_q;
    assign phase_done = phase_done_q;
    assign done       = (state_q == ST_DONE);

    logic [7:0] glyph_status;
    logic [7:0] glyph0;

    always_comb begin
        case (state_q)
            ST_FULL: glyph_status = GLYPH_F;
            ST_DONE: glyph_status = GLYPH_LOWER_D;
            default: glyph_status = GLYPH_DASH;
        endcase
        glyph0 = pause ? (glyph_status & DP_ON_MASK) : glyph_status;
    end

    led_phase_sequencer_seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .enable (state_q != ST_IDLE),
        .glyph3 (GLYPH_P),
        .glyph2 (GLYPH_BLANK),
        .glyph1 (hex_glyph(phase_q)),
        .glyph0 (glyph0),
        .seg    (seg),
        .an     (an)
    );

endmodule

// File: tb/tb_led_phase_sequencer.sv
// Bench for led_phase_sequencer: a manual-advance and an auto-advance instance
// checked every cycle against a time-based model plus directed literal checks.
module tb_led_phase_sequencer;

    localparam int LED_W      = 4;
    localparam int STEP_DIV   = 3;
    localparam int NUM_PHASES = 3;
    localparam int HOLD_DIV   = 2;
    localparam int SCAN_DIV   = 2;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_FULL = 2;
    localparam int M_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n_v;
    logic [1:0] start_v;
    logic [1:0] next_v;
    logic [1:0] pause_v;

    logic [LED_W-1:0] led_o   [2];
    logic [7:0]       seg_o   [2];
    logic [3:0]       an_o    [2];
    logic [3:0]       phase_o [2];
    logic             pd_o    [2];
    logic             done_o  [2];

    int checks   = 0;
    int failures = 0;

    led_phase_sequencer #(
        .LED_W(LED_W), .STEP_DIV(STEP_DIV), .NUM_PHASES(NUM_PHASES),
        .AUTO_ADVANCE(0), .HOLD_DIV(HOLD_DIV), .SCAN_DIV(SCAN_DIV)
    ) u_manual (
        .CLOCK(clk), .RESET_N(rst_n_v[0]), .start(start_v[0]), .next(next_v[0]),
        .pause(pause_v[0]), .LED(led_o[0]), .seg(seg_o[0]), .an(an_o[0]),
        .phase(phase_o[0]), .phase_done(pd_o[0]), .done(done_o[0])
    );

    led_phase_sequencer #(
        .LED_W(LED_W), .STEP_DIV(STEP_DIV), .NUM_PHASES(NUM_PHASES),
        .AUTO_ADVANCE(1), .HOLD_DIV(HOLD_DIV), .SCAN_DIV(SCAN_DIV)
    ) u_auto (
        .CLOCK(clk), .RESET_N(rst_n_v[1]), .start(start_v[1]), .next(next_v[1]),
        .pause(pause_v[1]), .LED(led_o[1]), .seg(seg_o[1]), .an(an_o[1]),
        .phase(phase_o[1]), .phase_done(pd_o[1]), .done(done_o[1])
    );

    // Model: bars lit = unpaused cycles since the sweep began / STEP_DIV;
    // digit on show = 3 - (cycles since reset / SCAN_DIV) mod 4.
    typedef struct {
        int mode;
        int phase;
        int lit;
        int elapsed;
        int held;
        int cycles;
        bit pd;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t m_reset();
        mdl_t r;
        r.mode = M_IDLE; r.phase = 0; r.lit = 0; r.elapsed = 0;
        r.held = 0; r.cycles = 0; r.pd = 1'b0;
        return r;
    endfunction

    function automatic mdl_t m_step(input mdl_t s, input bit st, input bit nx,
                                    input bit pz, input bit auto_mode);
        mdl_t r = s;
        bit   go;
        r.cycles = s.cycles + 1;
        r.pd     = 1'b0;
        go       = 1'b0;
        case (s.mode)
            M_IDLE, M_DONE: if (st) begin
                r.mode = M_FILL; r.phase = 0; r.lit = 0; r.elapsed = 0; r.held = 0;
            end
            M_FILL: begin
                if (s.lit == LED_W) begin
                    r.mode = M_FULL; r.pd = 1'b1; r.held = 0;
                end else if (!pz) begin
                    r.elapsed = s.elapsed + 1;
                    r.lit     = r.elapsed / STEP_DIV;
                end
            end
            default: begin
                if (s.phase == NUM_PHASES - 1) r.mode = M_DONE;
                else if (auto_mode) begin
                    if (!pz) begin
                        r.held = s.held + 1;
                        go     = (r.held == HOLD_DIV);
                    end
                end else go = nx;
                if (go) begin
                    r.mode = M_FILL; r.phase = s.phase + 1; r.lit = 0;
                    r.elapsed = 0; r.held = 0;
                end
            end
        endcase
        return r;
    endfunction

    function automatic int hex7(input int v);
        case (v)
            0: return 'hC0;  1: return 'hF9;  2: return 'hA4;  3: return 'hB0;
            4: return 'h99;  5: return 'h92;  6: return 'h82;  7: return 'hF8;
            8: return 'h80;  9: return 'h90; 10: return 'h88; 11: return 'h83;
            12: return 'hC6; 13: return 'hA1; 14: return 'h86; default: return 'h8E;
        endcase
    endfunction

    function automatic int exp_digit(input mdl_t s);
        return 3 - ((s.cycles / SCAN_DIV) % 4);
    endfunction

    function automatic int exp_an(input mdl_t s);
        if (s.mode == M_IDLE) return 'hF;
        return (~(1 << exp_digit(s))) & 'hF;
    endfunction

    function automatic int exp_seg(input mdl_t s, input bit pz);
        int base;
        if (s.mode == M_IDLE) return 'hFF;
        case (exp_digit(s))
            3: return 'h8C;
            2: return 'hFF;
            1: return hex7(s.phase);
            default: begin
                base = (s.mode == M_FULL) ? 'h8E : (s.mode == M_DONE) ? 'hA1 : 'hBF;
                return pz ? (base & 'h7F) : base;
            end
        endcase
    endfunction

    task automatic check(input string name, input int idx, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, idx, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            m[i] <= !rst_n_v[i] ? m_reset()
                  : m_step(m[i], start_v[i], next_v[i], pause_v[i], i == 1);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n_v[i]) begin
                check("model_led",   i, int'(led_o[i]),   (1 << m[i].lit) - 1);
                check("model_phase", i, int'(phase_o[i]), m[i].phase);
                check("model_pd",    i, int'(pd_o[i]),    int'(m[i].pd));
                check("model_done",  i, int'(done_o[i]),  int'(m[i].mode == M_DONE));
                check("model_an",    i, int'(an_o[i]),    exp_an(m[i]));
                check("model_seg",   i, int'(seg_o[i]),   exp_seg(m[i], pause_v[i]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n_v = 2'b00; start_v = 2'b00; next_v = 2'b00; pause_v = 2'b00;
        step(3);
        check("rst_led",   0, int'(led_o[0]),   0);
        check("rst_an",    0, int'(an_o[0]),    'hF);
        check("rst_seg",   0, int'(seg_o[0]),   'hFF);
        check("rst_phase", 0, int'(phase_o[0]), 0);
        check("rst_done",  0, int'(done_o[0]),  0);
        check("rst_pd",    1, int'(pd_o[1]),    0);
        rst_n_v = 2'b11;
        step(2);

        // Both instances start together; bar steps at cycles 3,6,9,12.
        start_v = 2'b11; step(1); start_v = 2'b00;
        check("an_after_start", 0, int'(an_o[0]), 'b1011);
        step(2);  check("led_c2",  0, int'(led_o[0]), 'b0000);
        step(1);  check("led_c3",  0, int'(led_o[0]), 'b0001);
        step(3);  check("led_c6",  0, int'(led_o[0]), 'b0011);
        step(3);  check("led_c9",  1, int'(led_o[1]), 'b0111);
        step(3);  check("led_c12", 0, int'(led_o[0]), 'b1111);
                  check("pd_c12",  0, int'(pd_o[0]),  0);
        step(1);  check("pd_c13",  0, int'(pd_o[0]),  1);
                  check("pd_c13",  1, int'(pd_o[1]),  1);
        step(1);  check("pd_c14",  0, int'(pd_o[0]),  0);

        // Auto instance: 3 fills + 2 holds finish at cycle 44.
        step(29); check("auto_done_c43", 1, int'(done_o[1]), 0);
        step(1);  check("auto_done_c44", 1, int'(done_o[1]), 1);
                  check("auto_phase",    1, int'(phase_o[1]), 2);
                  check("man_waiting",   0, int'(phase_o[0]), 0);

        // Manual advance, then a stray next during FILL.
        next_v[0] = 1'b1; step(1); next_v[0] = 1'b0;
        check("next_led",   0, int'(led_o[0]),   0);
        check("next_phase", 0, int'(phase_o[0]), 1);
        step(4);
        next_v[0] = 1'b1; step(1); next_v[0] = 1'b0;
        check("next_in_fill", 0, int'(phase_o[0]), 1);
        step(1);  check("led_before_pause", 0, int'(led_o[0]), 'b0011);

        // Pause for 5 cycles right after a step: next step lands 8 cycles later.
        pause_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("pause_led", 0, int'(led_o[0]), 'b0011);
            check("pause_dp",  0, int'(seg_o[0][7]), (an_o[0] == 4'b1110) ? 0 : 1);
        end
        pause_v[0] = 1'b0;
        step(2);  check("resume_c7", 0, int'(led_o[0]), 'b0011);
        step(1);  check("resume_c8", 0, int'(led_o[0]), 'b0111);
        step(4);  check("pd_phase1", 0, int'(pd_o[0]),  1);
        next_v[0] = 1'b1; step(1); next_v[0] = 1'b0;
        check("phase2", 0, int'(phase_o[0]), 2);
        step(13); check("pd_phase2", 0, int'(pd_o[0]),   1);
        step(1);  check("man_done",  0, int'(done_o[0]), 1);
                  check("done_led",  0, int'(led_o[0]),  'b1111);
        for (int k = 0; k < 10 && an_o[0] != 4'b1110; k++) step(1);
        check("done_digit0_an",  0, int'(an_o[0]),  'b1110);
        check("done_digit0_seg", 0, int'(seg_o[0]), 'hA1);

        // Restart from DONE, reach phase 1, then stray start and async reset.
        start_v[0] = 1'b1; step(1); start_v[0] = 1'b0;
        check("restart_phase", 0, int'(phase_o[0]), 0);
        check("restart_done",  0, int'(done_o[0]),  0);
        step(13); check("restart_pd", 0, int'(pd_o[0]), 1);
        next_v[0] = 1'b1; step(1); next_v[0] = 1'b0;
        step(4);
        start_v[0] = 1'b1; step(1); start_v[0] = 1'b0;
        check("start_in_fill_phase", 0, int'(phase_o[0]), 1);
        check("start_in_fill_led",   0, int'(led_o[0]),   'b0001);
        rst_n_v[0] = 1'b0;
        #2;
        check("async_led",   0, int'(led_o[0]),   0);
        check("async_phase", 0, int'(phase_o[0]), 0);
        check("async_an",    0, int'(an_o[0]),    'hF);
        check("async_seg",   0, int'(seg_o[0]),   'hFF);
        step(1);
        rst_n_v[0] = 1'b1;

        // Scan sequence from a freshly reset scan counter.
        start_v[0] = 1'b1; step(1); start_v[0] = 1'b0;
        check("scan_d3_an",  0, int'(an_o[0]),  'b0111);
        check("scan_d3_seg", 0, int'(seg_o[0]), 'h8C);
        step(1);  check("scan_d2_an",  0, int'(an_o[0]),  'b1011);
                  check("scan_d2_seg", 0, int'(seg_o[0]), 'hFF);
        step(2);  check("scan_d1_an",  0, int'(an_o[0]),  'b1101);
                  check("scan_d1_seg", 0, int'(seg_o[0]), 'hC0);
        step(2);  check("scan_d0_an",  0, int'(an_o[0]),  'b1110);
                  check("scan_d0_seg", 0, int'(seg_o[0]), 'hBF);
        step(2);  check("scan_wrap_an", 0, int'(an_o[0]), 'b0111);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
